axis_ps_upsizer: RTL and testbench
==================================

# axis_ps_upsizer

Parametrised AXI-Stream width upsizer on the PS clock domain. It packs IN_W-bit words from the PS DMA into OUT_W-bit words for the PS→PL async FIFO that feeds the wide PL datapath. It has full backpressure, a registered output stage, and optional end-of-packet flush with byte-valid (tkeep) marking of partially filled words.

## Interface
Parameters:
- IN_W, 32: input data width in bits; multiple of 8.
- OUT_W, 256: output data width in bits; integer multiple of IN_W. Ratio R = OUT_W/IN_W, with R ≥ 2.
- CNT_W, 16: width of the frame counter.

Ports:
- ps_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  IN_W  input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  OUT_W  packed output word.
- m_axis_tkeep  out  OUT_W/8  byte-valid mask.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready (async FIFO not full).
- frame_cnt  out  CNT_W  count of emitted m_axis_tlast beats; wraps modulo 2^CNT_W.

## Operation
- An input beat is accepted when s_axis_tvalid && s_axis_tready.
- Lane index lane (0..R-1) selects the slot for the next accepted word. Lane k occupies bits [k*IN_W +: IN_W]. The first word of each output beat goes in lane 0, the least-significant lane.
- Accepting a beat with lane < R-1, and not a flush, stores the word in the pack buffer and increments lane.
- Accepting a beat with lane == R-1, or a flush (see Configuration), does all of the following:
  - loads the buffer plus the current word into the output register;
  - sets m_axis_tvalid;
  - sets m_axis_tkeep to the filled lanes;
  - forces unfilled lanes' data to 0;
  - clears lane to 0 and clears the pack buffer.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. It depends only on registered state and m_axis_tready, never on s_axis_tvalid.
- Output beat completes on m_axis_tvalid && m_axis_tready. m_axis_tvalid falls unless a new beat loads in the same cycle.
- While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata/tkeep/tlast are held stable.
- frame_cnt increments on each completed output beat with m_axis_tlast = 1.
- Reset mid-operation discards the partial buffer and any pending output beat.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0.
  - frame_cnt = 0, lane = 0, pack buffer = 0.
  - s_axis_tready = 1 once rst deasserts.
- Latency: m_axis_tvalid rises 1 cycle after acceptance of the completing input beat.
- Throughput: with m_axis_tready held high, 1 input beat per cycle sustained and 1 output beat every R cycles, with no bubbles.
- Simultaneous output handshake and completing input beat in the same cycle: the new beat loads and m_axis_tvalid stays high.
- Backpressure: every input lane stalls while the output register is full and not draining. Nothing is overwritten and nothing is dropped.

## Configuration
- Macro: AXIS_UPSIZER_TLAST_FLUSH_EN.
- Defined:
  - An accepted beat with s_axis_tlast = 1 is a flush at any lane.
  - The output beat carries m_axis_tlast = 1.
  - m_axis_tkeep has ones for bytes of lanes 0..lane only.
- Not defined:
  - s_axis_tlast is ignored and only lane == R-1 emits.
  - m_axis_tlast is held at 0 and frame_cnt stays 0.
  - m_axis_tkeep is all ones on every valid beat.

## Test plan
- Full packet, default params, tready = 1: input 0x00000001..0x00000008, tlast on the 8th beat.
  - One output beat with tdata = 0x00000008_..._00000001 (lane 0 = 0x1) and tkeep = 0xFFFFFFFF.
  - m_axis_tvalid rises 1 cycle after the 8th acceptance.
  - With the macro, tlast = 1 and frame_cnt = 1.
- Partial flush (macro defined): 3 words 0xA, 0xB, 0xC with tlast on 0xC.
  - tdata lanes 0..2 = A, B, C and lanes 3..7 = 0.
  - tkeep = 0x00000FFF, tlast = 1.
- Backpressure: 16 words streamed with m_axis_tready = 0 for 10 cycles after the first output loads.
  - s_axis_tready = 0 throughout the stall.
  - Output held stable.
  - After release, 2 output beats arrive in order with no loss.
- Back-to-back with tready = 1: 64 consecutive words.
  - 8 output beats, spaced exactly 8 cycles apart.
  - s_axis_tready is never low.
- Reset mid-packet: assert rst after 5 words.
  - All outputs 0 immediately.
  - The next 8 words form a clean beat with word 0 in lane 0.
- Parametrised: IN_W = 64, OUT_W = 512 (R = 8), and IN_W = 32, OUT_W = 96 (R = 3).
  - Correct lane packing and tkeep width.
  - Output every R beats.

Source files
------------

// File: rtl/axis_ps_upsizer.sv
`timescale 1ns/1ps
// axis_ps_upsizer: packs IN_W-bit AXI-Stream words into OUT_W-bit words on ps_clk.
// The output stage is registered and supports full backpressure.
// Optional macro AXIS_UPSIZER_TLAST_FLUSH_EN: when it is defined, s_axis_tlast flushes
// a partially filled word. tkeep then marks the filled lanes, m_axis_tlast is set, and
// frame_cnt counts the emitted packets. When it is undefined, the block only emits full
// words, tkeep is all ones, and tlast/frame_cnt stay at 0.
module axis_ps_upsizer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 256,
    parameter int CNT_W = 16
) (
    input  logic                 ps_clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [OUT_W-1:0]     m_axis_tdata,
    output logic [OUT_W/8-1:0]   m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [CNT_W-1:0]     frame_cnt
);
    localparam int R      = OUT_W / IN_W;
    localparam int LANE_W = (R > 2) ? $clog2(R) : 1;
    localparam int IN_B   = IN_W / 8;
    localparam int KEEP_W = OUT_W / 8;

    logic [LANE_W-1:0] r_lane;
    logic [OUT_W-1:0]  r_buf;

    logic              w_accept;
    logic              w_last_lane;
    logic              w_flush;
    logic              w_emit;
    logic [OUT_W-1:0]  w_packed;
    logic [KEEP_W-1:0] w_keep;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_last_lane   = (r_lane == LANE_W'(R - 1));

`ifdef AXIS_UPSIZER_TLAST_FLUSH_EN
    assign w_flush = s_axis_tlast;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast;
    assign w_flush        = 1'b0;
`endif

    assign w_emit = w_accept && (w_last_lane || w_flush);

    // Merge the incoming word into its lane.
    // Lanes above r_lane in r_buf are always zero, so unfilled lanes come out as 0.
    always_comb begin
        w_packed = r_buf;
        w_keep   = '0;
        for (int k = 0; k < R; k++) begin
            if (LANE_W'(k) == r_lane) begin
                w_packed[k*IN_W +: IN_W] = s_axis_tdata;
            end
        end
`ifdef AXIS_UPSIZER_TLAST_FLUSH_EN
        for (int k = 0; k < R; k++) begin
            if (LANE_W'(k) <= r_lane) begin
                w_keep[k*IN_B +: IN_B] = '1;
            end
        end
`else
        w_keep = '1;
`endif
    end

    // Pack buffer and lane pointer: advance on each stored word, clear on emit.
    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (w_emit) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (w_accept) begin
            r_lane <= r_lane + LANE_W'(1);
            r_buf  <= w_packed;
        end
    end

    // Output register: load a completed word, otherwise drop valid once the beat drains.
    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (w_emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_packed;
            m_axis_tkeep  <= w_keep;
            m_axis_tlast  <= w_flush;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Count completed end-of-packet beats (modulo 2^CNT_W).
    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_ps_upsizer.sv
`timescale 1ns/1ps
module tb_axis_ps_upsizer;
    localparam int IN_W  = 32;
    localparam int OUT_W = 256;
    localparam int CNT_W = 16;
    localparam int R     = 8;
    localparam int KW    = OUT_W / 8;
`ifdef AXIS_UPSIZER_TLAST_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic ps_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 ps_clk = ~ps_clk;

    logic [IN_W-1:0]  s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tlast = 1'b0;
    logic             s_axis_tready;
    logic [OUT_W-1:0] m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic [CNT_W-1:0] frame_cnt;

    axis_ps_upsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
        .ps_clk(ps_clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .frame_cnt(frame_cnt)
    );

    // Two extra instances to cover other width ratios: R=3 (32->96) and R=8 (64->512).
    logic [63:0]  p_tdata = '0;
    logic         p_tvalid = 1'b0;
    logic         p_tlast = 1'b0;
    logic         p_mready = 1'b1;
    logic         r3_sready, r3_mlast, r3_mvalid;
    logic [95:0]  r3_mdata;
    logic [11:0]  r3_mkeep;
    logic [15:0]  r3_fcnt;
    logic         w64_sready, w64_mlast, w64_mvalid;
    logic [511:0] w64_mdata;
    logic [63:0]  w64_mkeep;
    logic [15:0]  w64_fcnt;

    axis_ps_upsizer #(.IN_W(32), .OUT_W(96), .CNT_W(16)) u_r3 (
        .ps_clk(ps_clk), .rst(rst),
        .s_axis_tdata(p_tdata[31:0]), .s_axis_tvalid(p_tvalid),
        .s_axis_tlast(p_tlast), .s_axis_tready(r3_sready),
        .m_axis_tdata(r3_mdata), .m_axis_tkeep(r3_mkeep),
        .m_axis_tlast(r3_mlast), .m_axis_tvalid(r3_mvalid),
        .m_axis_tready(p_mready), .frame_cnt(r3_fcnt)
    );

    axis_ps_upsizer #(.IN_W(64), .OUT_W(512), .CNT_W(16)) u_w64 (
        .ps_clk(ps_clk), .rst(rst),
        .s_axis_tdata(p_tdata), .s_axis_tvalid(p_tvalid),
        .s_axis_tlast(p_tlast), .s_axis_tready(w64_sready),
        .m_axis_tdata(w64_mdata), .m_axis_tkeep(w64_mkeep),
        .m_axis_tlast(w64_mlast), .m_axis_tvalid(w64_mvalid),
        .m_axis_tready(p_mready), .frame_cnt(w64_fcnt)
    );

    int cyc = 0;
    always @(posedge ps_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string nm, logic [511:0] act, logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a list of pending words; a beat forms at R words, or at tlast when flushing.
    typedef struct {
        logic [OUT_W-1:0] data;
        logic [KW-1:0]    keep;
        logic             last;
    } beat_t;

    logic [IN_W-1:0] m_words[$];
    beat_t           exp_q[$];
    int              exp_frames = 0;

    function automatic void model_push(logic [IN_W-1:0] w, logic last);
        beat_t b;
        m_words.push_back(w);
        if (m_words.size() == R || (FLUSH && last)) begin
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < m_words.size(); i++) begin
                b.data = b.data | (OUT_W'(m_words[i]) << (i * IN_W));
                b.keep = b.keep | (KW'(4'hF) << (4 * i));
            end
            if (!FLUSH) b.keep = '1;
            b.last = FLUSH && last;
            exp_q.push_back(b);
            m_words.delete();
        end
    endfunction

    int               n_beats = 0;
    int               beat_cyc[$];
    int               s_ready_low = 0;
    logic [OUT_W-1:0] last_data;
    logic [KW-1:0]    last_keep;
    logic             last_last;

    // Main-DUT monitor: scoreboard on output handshakes and during stalls, model fed by accepts.
    initial begin
        beat_t b;
        forever begin
            @(negedge ps_clk);
            if (rst) begin
                if (!s_axis_tready) s_ready_low++;
                if (m_axis_tvalid && !m_axis_tready) begin
                    check("stall_has_exp", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        check("stall_data", m_axis_tdata, exp_q[0].data);
                        check("stall_keep", m_axis_tkeep, exp_q[0].keep);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    n_beats++;
                    beat_cyc.push_back(cyc);
                    last_data = m_axis_tdata;
                    last_keep = m_axis_tkeep;
                    last_last = m_axis_tlast;
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, b.data);
                        check("beat_keep", m_axis_tkeep, b.keep);
                        check("beat_last", m_axis_tlast, b.last);
                        if (b.last) exp_frames++;
                    end
                end
                if (s_axis_tvalid && s_axis_tready) model_push(s_axis_tdata, s_axis_tlast);
            end
        end
    end

    typedef struct { logic [95:0] d; logic [11:0] k; int c; } b3_t;
    typedef struct { logic [511:0] d; logic [63:0] k; int c; } b64_t;
    b3_t  got3[$];
    b64_t got64[$];

    initial begin
        forever begin
            @(negedge ps_clk);
            if (rst) begin
                if (r3_mvalid)  got3.push_back('{r3_mdata, r3_mkeep, cyc});
                if (w64_mvalid) got64.push_back('{w64_mdata, w64_mkeep, cyc});
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge ps_clk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        m_words.delete();
        exp_q.delete();
        exp_frames  = 0;
        n_beats     = 0;
        beat_cyc.delete();
        s_ready_low = 0;
        @(posedge ps_clk);
        @(posedge ps_clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_s_tready", s_axis_tready, 1);
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(logic [IN_W-1:0] w, logic last);
        bit ok;
        int t;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        s_axis_tlast  = last;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge ps_clk);
            ok = s_axis_tready;
            @(posedge ps_clk);
            #1;
            t++;
        end
        if (!ok) check("send_timeout", ok, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(string nm);
        int t;
        m_axis_tready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && t < 100) begin
            idle(1);
            t++;
        end
        idle(2);
        check(nm, exp_q.size(), 0);
    endtask

    typedef struct {
        int          nwords;
        logic [31:0] base;
        logic [31:0] step;
        int          exp_beats;
        logic [31:0] exp_keep;
        logic        exp_last;
        int          exp_frames;
    } vec_t;

    vec_t        tbl[5];
    logic [63:0] pw[24];
    bit          rnd_done;

    initial begin
        tbl[0] = '{8,  32'h1,         32'h1,  1,                  32'hFFFF_FFFF,                1'(FLUSH), FLUSH ? 1 : 0};
        tbl[1] = '{3,  32'hA,         32'h1,  FLUSH ? 1 : 0,      32'h0000_0FFF,                1'b1,      FLUSH ? 1 : 0};
        tbl[2] = '{16, 32'h100,       32'h11, 2,                  32'hFFFF_FFFF,                1'(FLUSH), FLUSH ? 1 : 0};
        tbl[3] = '{1,  32'hDEAD_BEEF, 32'h1,  FLUSH ? 1 : 0,      32'h0000_000F,                1'b1,      FLUSH ? 1 : 0};
        tbl[4] = '{10, 32'h5000_0000, 32'h3,  FLUSH ? 2 : 1,      FLUSH ? 32'hFF : 32'hFFFF_FFFF, 1'(FLUSH), FLUSH ? 1 : 0};

        #2;
        do_reset();

        // Other ratios: 24 consecutive words into the R=3 and R=8 (64-bit) instances.
        for (int i = 0; i < 24; i++) pw[i] = {$urandom, $urandom};
        for (int i = 0; i < 24; i++) begin
            p_tvalid = 1'b1;
            p_tdata  = pw[i];
            @(posedge ps_clk);
            #1;
        end
        p_tvalid = 1'b0;
        idle(4);
        check("r3_beats", got3.size(), 8);
        for (int b = 0; b < got3.size() && b < 8; b++) begin
            logic [95:0] e3;
            e3 = {pw[3*b+2][31:0], pw[3*b+1][31:0], pw[3*b][31:0]};
            check("r3_data", got3[b].d, e3);
            check("r3_keep", got3[b].k, 12'hFFF);
            if (b > 0) check("r3_spacing", got3[b].c - got3[b-1].c, 3);
        end
        check("w64_beats", got64.size(), 3);
        for (int b = 0; b < got64.size() && b < 3; b++) begin
            logic [511:0] e64;
            e64 = '0;
            for (int j = 0; j < 8; j++) e64 = e64 | (512'(pw[8*b+j]) << (64 * j));
            check("w64_data", got64[b].d, e64);
            check("w64_keep", got64[b].k, 64'hFFFF_FFFF_FFFF_FFFF);
            if (b > 0) check("w64_spacing", got64[b].c - got64[b-1].c, 8);
        end

        // Table of single packets, each from a clean reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < tbl[v].nwords; i++)
                send(tbl[v].base + tbl[v].step * 32'(i), i == tbl[v].nwords - 1);
            drain("tbl_drained");
            check("tbl_beats", n_beats, tbl[v].exp_beats);
            if (tbl[v].exp_beats > 0) begin
                check("tbl_keep", last_keep, tbl[v].exp_keep);
                check("tbl_last", last_last, tbl[v].exp_last);
            end
            check("tbl_frame_cnt", frame_cnt, tbl[v].exp_frames);
        end

        // Latency and explicit lane order.
        do_reset();
        for (int i = 1; i <= 7; i++) send(32'(i), 1'b0);
        check("lat_before", m_axis_tvalid, 0);
        send(32'd8, 1'b1);
        check("lat_valid", m_axis_tvalid, 1);
        check("lat_data", m_axis_tdata,
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        check("lat_keep", m_axis_tkeep, 32'hFFFF_FFFF);
        drain("lat_drained");

        // Backpressure: stall the output 10 cycles while 16 words are offered.
        do_reset();
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'h2000 + 32'(i), i == 15);
            end
            begin
                int t;
                t = 0;
                while (!m_axis_tvalid && t < 100) begin
                    idle(1);
                    t++;
                end
                check("bp_first_load", m_axis_tvalid, 1);
                m_axis_tready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge ps_clk);
                    check("bp_s_tready", s_axis_tready, 0);
                end
                @(posedge ps_clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        drain("bp_drained");
        check("bp_beats", n_beats, 2);

        // Back-to-back: 64 words, output every 8 cycles, no input stall.
        do_reset();
        for (int i = 0; i < 64; i++) send(32'h3000_0000 + 32'(i), 1'b0);
        drain("b2b_drained");
        check("b2b_beats", n_beats, 8);
        for (int i = 1; i < beat_cyc.size(); i++)
            check("b2b_spacing", beat_cyc[i] - beat_cyc[i-1], 8);
        check("b2b_ready_low", s_ready_low, 0);

        // Reset mid-packet: 13 words, reset, then a fresh 8-word beat.
        do_reset();
        for (int i = 0; i < 13; i++) send(32'h4000 + 32'(i), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(32'h7700 + 32'(i), 1'b0);
        drain("rst_mid_drained");
        check("rst_mid_beats", n_beats, 1);
        check("rst_mid_lane0", last_data[31:0], 32'h7700);

        // Randomized traffic with random gaps, tlast and backpressure.
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send($urandom, $urandom_range(0, 4) == 0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_axis_tready = ($urandom_range(0, 9) < 7);
                    @(posedge ps_clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        drain("rnd_drained");
        check("rnd_frame_cnt", frame_cnt, CNT_W'(exp_frames));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
